branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Execute-stage branch/jump resolution unit for the RV64 core.
- Evaluates BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR.
- Compares the outcome with the front-end prediction and issues a one-cycle redirect on mispredict.
- Single-entry registered output with valid/ready handshake, flush support and saturating branch/mispredict counters for perf reporting.

Parameters:
- XLEN, 64, operand and PC width.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid from issue.
- in_ready  out  1  unit can accept a request this cycle.
- in_funct3  in  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- in_is_jal  in  1  unconditional JAL.
- in_is_jalr  in  1  unconditional JALR.
- in_pc  in  XLEN  instruction PC.
- in_imm  in  XLEN  sign-extended offset.
- in_op1  in  XLEN  rs1 value.
- in_op2  in  XLEN  rs2 value.
- in_pred_taken  in  1  front-end prediction.
- in_pred_target  in  XLEN  predicted target.
- flush  in  1  pipeline kill.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_taken  out  1  resolved direction.
- out_target  out  XLEN  resolved target.
- out_link  out  XLEN  in_pc+4 (rd value for JAL/JALR).
- out_mispredict  out  1  redirect required.
- out_redirect_pc  out  XLEN  fetch restart PC.
- out_misalign  out  1  taken target has bit1 set.
- out_illegal  out  1  funct3 010/011 on a conditional branch.
- br_cnt  out  CNT_W  resolved-branch counter.
- mp_cnt  out  CNT_W  mispredict counter.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, every out_* data field=0, br_cnt=0, mp_cnt=0. in_ready=1 once reset is released.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - An input fires on in_valid && in_ready && !flush.
  - Result registers exactly one cycle after fire, giving latency 1.
  - The output holds stable while out_valid && !out_ready.
  - out_valid clears when the result is accepted and no new input fires.
  - Accept and fire in the same cycle gives back-to-back throughput of 1 per cycle.
- Compare semantics:
  - eq = (op1==op2).
  - Signed lt: if MSBs differ, lt = op1[XLEN-1]; otherwise unsigned compare of the low XLEN-1 bits.
  - Unsigned ltu: if MSBs differ, ltu = op2[XLEN-1]; otherwise the same low-bit compare.
  - BGE = !lt. BGEU = !ltu. BNE = !eq.
- Priority: JALR > JAL > conditional.
- Targets:
  - JAL and conditional branches: in_pc+in_imm (mod 2^XLEN, wraps silently).
  - JALR: (in_op1+in_imm) with bit0 cleared.
  - JAL and JALR: taken=1.
- Illegal funct3 (010/011, not a jump): taken=0, out_illegal=1, mispredict=0, counters unchanged.
- Misalign: if taken && target[1]: out_misalign=1, mispredict=0, redirect_pc=target (trap logic owns it).
- Mispredict = (taken != pred_taken) || (taken && target != pred_target).
  - redirect_pc = taken ? target : in_pc+4.
  - Not-taken with pred_taken=0 ignores pred_target.
- Flush:
  - Synchronous. Clears out_valid next cycle regardless of out_ready.
  - An input presented in the flush cycle is dropped; in_ready may still read 1.
  - Counters are not updated for dropped or flushed entries.
- Counters:
  - br_cnt increments on each fire of a legal conditional branch or jump.
  - mp_cnt increments on each fire with mispredict=1.
  - Both saturate at 2^CNT_W-1.
- Reset mid-transaction discards the held result immediately (async).

Test Plan:
- BLT op1=0xFFFF_FFFF_FFFF_FFFF (-1), op2=1, pred_taken=0, pc=0x8000_0000, imm=0x10 -> next cycle out_taken=1, target=0x8000_0010, mispredict=1, redirect=0x8000_0010, mp_cnt=1.
- BLTU same operands, pred_taken=0 -> out_taken=0, mispredict=0, out_link=0x8000_0004, br_cnt increments, mp_cnt unchanged.
- JALR op1=0x8000_1001, imm=4, pred_target=0x8000_1004, pred_taken=1 -> target=0x8000_1004 (bit0 cleared), mispredict=0; repeat with imm=6 -> target=0x8000_1006, out_misalign=1, mispredict=0.
- Back-pressure: two BEQ (op1=op2=5) back-to-back with out_ready=0 for 3 cycles -> in_ready=0 while full, first result held stable; out_ready=1 -> both results delivered in consecutive cycles, br_cnt=2.
- Flush asserted while out_valid=1, out_ready=0, and a new in_valid=1 -> next cycle out_valid=0, counters unchanged by the dropped input.
- funct3=010 with in_valid -> out_illegal=1, out_taken=0, br_cnt unchanged. Then preload: force br_cnt to 2^CNT_W-1, fire BEQ -> br_cnt stays at max.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Request/response bundle between issue, the branch resolve unit and its consumer.
interface branch_resolve_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic            in_is_jal;
  logic            in_is_jalr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_op1;
  logic [XLEN-1:0] in_op2;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_target;

  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_link;
  logic            out_mispredict;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_misalign;
  logic            out_illegal;

  modport master (
    output in_valid, in_funct3, in_is_jal, in_is_jalr, in_pc, in_imm,
           in_op1, in_op2, in_pred_taken, in_pred_target, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_link,
           out_mispredict, out_redirect_pc, out_misalign, out_illegal
  );

  modport slave (
    input  in_valid, in_funct3, in_is_jal, in_is_jalr, in_pc, in_imm,
           in_op1, in_op2, in_pred_taken, in_pred_target, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_link,
           out_mispredict, out_redirect_pc, out_misalign, out_illegal
  );
endinterface

// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolution: evaluates the condition, forms the
// target and link, compares against the front-end prediction and holds the
// result in a single-entry output register with valid/ready and flush.
module branch_resolve #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_resolve_if.slave   bus,
  input  logic              flush,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  mp_cnt
);

  localparam logic [XLEN-1:0]  PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0]  BIT0_MASK = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Less-than on raw operands: MSBs decide when they differ, otherwise the
  // remaining bits compare unsigned for both signed and unsigned flavours.
  function automatic logic less_than(input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b,
                                     input logic            is_signed);
    if (a[XLEN-1] != b[XLEN-1])
      return is_signed ? a[XLEN-1] : b[XLEN-1];
    return (a[XLEN-2:0] < b[XLEN-2:0]);
  endfunction

  // Saturating increment for the perf counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             en);
    if (en && (c != {CNT_W{1'b1}}))
      return c + CNT_ONE;
    return c;
  endfunction

  logic            out_valid_q,      out_valid_d;
  logic            out_taken_q,      out_taken_d;
  logic [XLEN-1:0] out_target_q,     out_target_d;
  logic [XLEN-1:0] out_link_q,       out_link_d;
  logic            out_mispredict_q, out_mispredict_d;
  logic [XLEN-1:0] out_redirect_q,   out_redirect_d;
  logic            out_misalign_q,   out_misalign_d;
  logic            out_illegal_q,    out_illegal_d;
  logic [CNT_W-1:0] br_cnt_q,        br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q,        mp_cnt_d;

  logic            in_ready;
  logic            fire;
  logic            is_jump;
  logic            illegal;
  logic            eq;
  logic            lt;
  logic            ltu;
  logic            cond_taken;
  logic            taken;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic            misalign;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  // Resolve the incoming request: condition, target, link and prediction check.
  always_comb begin
    in_ready  = !out_valid_q || bus.out_ready;
    fire      = bus.in_valid && in_ready && !flush;
    is_jump   = bus.in_is_jal || bus.in_is_jalr;
    illegal   = !is_jump && (bus.in_funct3[2:1] == 2'b01);

    eq  = (bus.in_op1 == bus.in_op2);
    lt  = less_than(bus.in_op1, bus.in_op2, 1'b1);
    ltu = less_than(bus.in_op1, bus.in_op2, 1'b0);

    cond_taken = 1'b0;
    case (bus.in_funct3)
      3'b000:  cond_taken = eq;
      3'b001:  cond_taken = !eq;
      3'b100:  cond_taken = lt;
      3'b101:  cond_taken = !lt;
      3'b110:  cond_taken = ltu;
      3'b111:  cond_taken = !ltu;
      default: cond_taken = 1'b0;
    endcase

    taken     = is_jump || (!illegal && cond_taken);
    br_target = bus.in_pc + bus.in_imm;
    jalr_sum  = bus.in_op1 + bus.in_imm;
    target    = bus.in_is_jalr ? (jalr_sum & BIT0_MASK) : br_target;
    link      = bus.in_pc + PC_STEP;

    // A misaligned taken target is a trap, not a redirect.
    misalign    = taken && target[1];
    mispredict  = !illegal && !misalign &&
                  ((taken != bus.in_pred_taken) ||
                   (taken && (target != bus.in_pred_target)));
    redirect_pc = taken ? target : link;
  end

  // Next-state for the output register and counters.
  always_comb begin
    out_valid_d      = out_valid_q;
    out_taken_d      = out_taken_q;
    out_target_d     = out_target_q;
    out_link_d       = out_link_q;
    out_mispredict_d = out_mispredict_q;
    out_redirect_d   = out_redirect_q;
    out_misalign_d   = out_misalign_q;
    out_illegal_d    = out_illegal_q;
    br_cnt_d         = br_cnt_q;
    mp_cnt_d         = mp_cnt_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d      = 1'b1;
      out_taken_d      = taken;
      out_target_d     = target;
      out_link_d       = link;
      out_mispredict_d = mispredict;
      out_redirect_d   = redirect_pc;
      out_misalign_d   = misalign;
      out_illegal_d    = illegal;
      br_cnt_d         = sat_inc(br_cnt_q, !illegal);
      mp_cnt_d         = sat_inc(mp_cnt_q, mispredict);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and counters; async reset discards any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_target_q     <= '0;
      out_link_q       <= '0;
      out_mispredict_q <= 1'b0;
      out_redirect_q   <= '0;
      out_misalign_q   <= 1'b0;
      out_illegal_q    <= 1'b0;
      br_cnt_q         <= '0;
      mp_cnt_q         <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_taken_q      <= out_taken_d;
      out_target_q     <= out_target_d;
      out_link_q       <= out_link_d;
      out_mispredict_q <= out_mispredict_d;
      out_redirect_q   <= out_redirect_d;
      out_misalign_q   <= out_misalign_d;
      out_illegal_q    <= out_illegal_d;
      br_cnt_q         <= br_cnt_d;
      mp_cnt_q         <= mp_cnt_d;
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_taken       = out_taken_q;
  assign bus.out_target      = out_target_q;
  assign bus.out_link        = out_link_q;
  assign bus.out_mispredict  = out_mispredict_q;
  assign bus.out_redirect_pc = out_redirect_q;
  assign bus.out_misalign    = out_misalign_q;
  assign bus.out_illegal     = out_illegal_q;
  assign br_cnt              = br_cnt_q;
  assign mp_cnt              = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: driver pushes model results at fire,
// monitor pops and compares whenever the unit presents a result.
module tb_branch_resolve;
  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct {
    logic [2:0]  f3;
    logic        jal;
    logic        jalr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] op1;
    logic [63:0] op2;
    logic        pt;
    logic [63:0] ptg;
  } req_t;

  typedef struct packed {
    logic        taken;
    logic [63:0] target;
    logic [63:0] link;
    logic [63:0] redir;
    logic        mp;
    logic        mis;
    logic        ill;
    logic [3:0]  br;
    logic [3:0]  mpc;
    logic [51:0] pad;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mp_cnt;

  branch_resolve_if #(.XLEN(XLEN)) bus ();

  branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .flush  (flush),
    .br_cnt (br_cnt),
    .mp_cnt (mp_cnt)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  int   m_br = 0;
  int   m_mp = 0;
  logic model_full = 1'b0;
  logic last_fire  = 1'b0;
  logic last_fl    = 1'b0;
  logic last_ordy  = 1'b0;
  logic fire_now   = 1'b0;
  logic stop_mon   = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chkc(input string name, input logic [CNT_W-1:0] act, input int exp);
    logic [31:0] e32;
    e32 = exp;
    checks++;
    if (act !== e32[CNT_W-1:0]) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chkr(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual taken=%b tgt=%h link=%h redir=%h mp=%b mis=%b ill=%b br=%0d mpc=%0d expected taken=%b tgt=%h link=%h redir=%h mp=%b mis=%b ill=%b br=%0d mpc=%0d",
               name, act.taken, act.target, act.link, act.redir, act.mp, act.mis, act.ill, act.br, act.mpc,
               exp.taken, exp.target, exp.link, exp.redir, exp.mp, exp.mis, exp.ill, exp.br, exp.mpc);
    end
  endtask

  // Reference: architectural branch rules with plain signed/unsigned arithmetic.
  function automatic exp_t calc(input req_t r);
    exp_t e;
    logic [63:0] sum;
    e = '0;
    e.link = r.pc + 64'd4;
    if (r.jalr) begin
      e.taken  = 1'b1;
      sum      = r.op1 + r.imm;
      e.target = {sum[63:1], 1'b0};
    end else if (r.jal) begin
      e.taken  = 1'b1;
      e.target = r.pc + r.imm;
    end else begin
      e.target = r.pc + r.imm;
      case (r.f3)
        3'd0:    e.taken = (r.op1 == r.op2);
        3'd1:    e.taken = (r.op1 != r.op2);
        3'd4:    e.taken = ($signed(r.op1) <  $signed(r.op2));
        3'd5:    e.taken = ($signed(r.op1) >= $signed(r.op2));
        3'd6:    e.taken = (r.op1 <  r.op2);
        3'd7:    e.taken = (r.op1 >= r.op2);
        default: e.ill   = 1'b1;
      endcase
    end
    e.mis   = e.taken && e.target[1];
    e.redir = e.taken ? e.target : e.link;
    e.mp    = !e.ill && !e.mis &&
              ((e.taken != r.pt) || (e.taken && (e.target != r.ptg)));
    return e;
  endfunction

  function automatic req_t mk(input logic [2:0] f3, input logic jal, input logic jalr,
                              input logic [63:0] pc, input logic [63:0] imm,
                              input logic [63:0] op1, input logic [63:0] op2,
                              input logic pt, input logic [63:0] ptg);
    req_t r;
    r.f3 = f3; r.jal = jal; r.jalr = jalr; r.pc = pc; r.imm = imm;
    r.op1 = op1; r.op2 = op2; r.pt = pt; r.ptg = ptg;
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] pick_op();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return {64{1'b1}};
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'd5;
      default: return rnd64();
    endcase
  endfunction

  function automatic req_t rand_req();
    req_t r;
    logic [63:0] t;
    exp_t e;
    case ($urandom_range(0, 9))
      0: r.f3 = 3'd0; 1: r.f3 = 3'd1; 2: r.f3 = 3'd4; 3: r.f3 = 3'd5;
      4: r.f3 = 3'd6; 5: r.f3 = 3'd7; 6: r.f3 = 3'd0; 7: r.f3 = 3'd2;
      8: r.f3 = 3'd3; default: r.f3 = 3'd5;
    endcase
    r.jal  = ($urandom_range(0, 7) == 0);
    r.jalr = ($urandom_range(0, 7) == 0);
    r.pc   = rnd64() & ~64'h3;
    t      = rnd64();
    r.imm  = {{51{t[12]}}, t[12:0]};
    r.op1  = pick_op();
    r.op2  = pick_op();
    r.pt   = ($urandom_range(0, 1) == 1);
    e      = calc(r);
    r.ptg  = ($urandom_range(0, 1) == 1) ? e.target : rnd64();
    return r;
  endfunction

  // One clock of stimulus; advances the model's view of the output slot.
  task automatic step(input req_t r, input logic v, input logic ordy, input logic fl);
    exp_t e;
    logic exp_rdy;
    logic fire;
    @(posedge clk);
    #2;
    if (last_fl)        model_full = 1'b0;
    else if (last_fire) model_full = 1'b1;
    else if (last_ordy) model_full = 1'b0;
    bus.in_valid       = v;
    bus.in_funct3      = r.f3;
    bus.in_is_jal      = r.jal;
    bus.in_is_jalr     = r.jalr;
    bus.in_pc          = r.pc;
    bus.in_imm         = r.imm;
    bus.in_op1         = r.op1;
    bus.in_op2         = r.op2;
    bus.in_pred_taken  = r.pt;
    bus.in_pred_target = r.ptg;
    bus.out_ready      = ordy;
    flush              = fl;
    #1;
    exp_rdy = !model_full || ordy;
    chk1("in_ready", bus.in_ready, exp_rdy);
    fire = v && exp_rdy && !fl;
    if (fire) begin
      e = calc(r);
      if (!e.ill && m_br < MAXC) m_br++;
      if (e.mp && m_mp < MAXC)   m_mp++;
      e.br  = m_br[3:0];
      e.mpc = m_mp[3:0];
      q.push_back(e);
    end
    fire_now  = fire;
    last_fire = fire;
    last_fl   = fl;
    last_ordy = ordy;
  endtask

  // Monitor: compare the presented result with the scoreboard head.
  initial begin
    exp_t a;
    int   vis;
    forever begin
      @(negedge clk);
      if (rst_n && !stop_mon) begin
        vis = q.size() - (fire_now ? 1 : 0);
        if (bus.out_valid) begin
          if (vis <= 0) begin
            chk1("unexpected_out_valid", 1'b1, 1'b0);
          end else begin
            a        = '0;
            a.taken  = bus.out_taken;
            a.target = bus.out_target;
            a.link   = bus.out_link;
            a.redir  = bus.out_redirect_pc;
            a.mp     = bus.out_mispredict;
            a.mis    = bus.out_misalign;
            a.ill    = bus.out_illegal;
            a.br     = br_cnt;
            a.mpc    = mp_cnt;
            chkr("result", a, q[0]);
            if (bus.out_ready || flush) void'(q.pop_front());
          end
        end else if (vis > 0) begin
          chk1("missing_result", 1'b0, 1'b1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    req_t idle;
    req_t r;
    req_t beq;
    logic v;
    logic o;
    logic f;
    idle = mk(3'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0);
    bus.in_valid = 1'b0; bus.in_funct3 = 3'd0; bus.in_is_jal = 1'b0; bus.in_is_jalr = 1'b0;
    bus.in_pc = '0; bus.in_imm = '0; bus.in_op1 = '0; bus.in_op2 = '0;
    bus.in_pred_taken = 1'b0; bus.in_pred_target = '0; bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_data_zero", (bus.out_taken | bus.out_mispredict | bus.out_misalign | bus.out_illegal |
                           (|bus.out_target) | (|bus.out_link) | (|bus.out_redirect_pc)), 1'b0);
    chkc("rst_br_cnt", br_cnt, 0);
    chkc("rst_mp_cnt", mp_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("rst_in_ready", bus.in_ready, 1'b1);

    // BLT -1 < 1 predicted not-taken, then BLTU same operands
    r = mk(3'b100, 1'b0, 1'b0, 64'h8000_0000, 64'h10, {64{1'b1}}, 64'd1, 1'b0, 64'd0);
    step(r, 1'b1, 1'b1, 1'b0);
    r.f3 = 3'b110;
    step(r, 1'b1, 1'b1, 1'b0);
    // JALR clearing bit0, then with a misaligned target
    r = mk(3'd0, 1'b0, 1'b1, 64'h8000_0000, 64'd4, 64'h8000_1001, 64'd0, 1'b1, 64'h8000_1004);
    step(r, 1'b1, 1'b1, 1'b0);
    r.imm = 64'd6;
    step(r, 1'b1, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b1, 1'b0);
    chkc("plan_mp_cnt", mp_cnt, 1);
    chkc("plan_br_cnt", br_cnt, 4);

    // Back-pressure: two BEQ with the consumer stalled
    beq = mk(3'd0, 1'b0, 1'b0, 64'h100, 64'h20, 64'd5, 64'd5, 1'b1, 64'h120);
    repeat (4) step(beq, 1'b1, 1'b0, 1'b0);
    step(beq, 1'b1, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b1, 1'b0);
    chkc("bp_br_cnt", br_cnt, 6);

    // Flush while holding a result with a new request presented
    step(beq, 1'b1, 1'b0, 1'b0);
    step(beq, 1'b1, 1'b0, 1'b1);
    step(idle, 1'b0, 1'b0, 1'b0);
    chk1("flush_clears_valid", bus.out_valid, 1'b0);
    chkc("flush_br_cnt", br_cnt, m_br);
    chkc("flush_mp_cnt", mp_cnt, m_mp);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = rand_req();
      v = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 9) == 0);
      o = f ? 1'b0 : ($urandom_range(0, 9) < 7);
      step(r, v, o, f);
    end
    step(idle, 1'b0, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b1, 1'b0);

    // Illegal funct3, then a BEQ at counter saturation
    r = mk(3'b010, 1'b0, 1'b0, 64'h2000, 64'h8, 64'd1, 64'd1, 1'b1, 64'h2008);
    step(r, 1'b1, 1'b1, 1'b0);
    step(beq, 1'b1, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b1, 1'b0);
    step(idle, 1'b0, 1'b1, 1'b0);
    chkc("sat_br_cnt", br_cnt, MAXC);
    chkc("end_mp_cnt", mp_cnt, m_mp);
    chk1("scoreboard_drained", (q.size() == 0), 1'b1);

    // Reset while a result is held
    step(beq, 1'b1, 1'b0, 1'b0);
    step(idle, 1'b0, 1'b0, 1'b0);
    chk1("held_before_reset", bus.out_valid, 1'b1);
    stop_mon = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_valid", bus.out_valid, 1'b0);
    chkc("async_rst_br_cnt", br_cnt, 0);
    q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
